reg_file_sb: RTL

- Integer register file with a long-latency scoreboard. It is the receiving end of the writeback interface: it consumes the gated write enable, destination address and selected write data.
- Provides two decode-stage read ports with write-first bypass.
- Tracks outstanding destination writes of long-latency ops (loads, divides) so decode can stall on RAW hazards.
- Sits between stage02 decode (reads) and stage05 writeback (writes).

---
 rtl/reg_file_sb_pkg.sv | 10 +
 rtl/reg_file_sb_if.sv | 36 +++
 rtl/reg_file_sb_counter.sv | 46 ++++
 rtl/reg_file_sb.sv | 93 +++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared parameters and types for the register file and its scoreboard.
package reg_file_sb_pkg;

    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned PEND_W_DEFAULT = 2;

    typedef logic [4:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-read, long-op issue and writeback signals of the register file.
interface reg_file_sb_if #(
    parameter int unsigned XLEN = 32
);
    import reg_file_sb_pkg::*;

    reg_addr_t         rs1_addr_i;
    reg_addr_t         rs2_addr_i;
    logic [XLEN-1:0]   rs1_data_o;
    logic [XLEN-1:0]   rs2_data_o;
    logic              rs1_busy_o;
    logic              rs2_busy_o;
    logic              iss_en_i;
    reg_addr_t         iss_rd_i;
    logic              iss_full_o;
    logic              rf_rw_en_i;
    reg_addr_t         wb_rd_i;
    logic [XLEN-1:0]   wb_data_i;
    logic              wb_long_i;
    logic              sb_err_o;

    // Pipeline side: decode, execute issue and writeback.
    modport master (
        output rs1_addr_i, rs2_addr_i, iss_en_i, iss_rd_i,
               rf_rw_en_i, wb_rd_i, wb_data_i, wb_long_i,
        input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, iss_full_o, sb_err_o
    );

    // Register file side.
    modport slave (
        input  rs1_addr_i, rs2_addr_i, iss_en_i, iss_rd_i,
               rf_rw_en_i, wb_rd_i, wb_data_i, wb_long_i,
        output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, iss_full_o, sb_err_o
    );

endinterface

// File: rtl/reg_file_sb_counter.sv
// Saturating up/down pending counter for one architectural register.
module reg_file_sb_counter #(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_req,
    input  logic              dec_req,
    output logic [PEND_W-1:0] cnt,
    output logic              full,
    output logic              zero,
    output logic              dec
);

    localparam logic [PEND_W-1:0] CntMax = '1;

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;
    logic              inc;

    // A retire frees a slot in the same cycle, so it lifts saturation.
    always_comb begin
        zero  = (cnt_q == '0);
        dec   = dec_req && !zero;
        full  = (cnt_q == CntMax) && !dec;
        inc   = inc_req && !full;
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    // Pending count register; reset drops all outstanding state at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-first bypass and long-latency scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned PEND_W = PEND_W_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    reg_file_sb_if.slave  bus
);

    logic [XLEN-1:0]   regs_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_vec  [NUM_REGS];
    logic              full_vec [NUM_REGS];
    logic              zero_vec [NUM_REGS];
    logic              dec_vec  [NUM_REGS];
    logic              wb_long_hit;
    logic              underflow;
    logic              sb_err_q;

    assign wb_long_hit = bus.rf_rw_en_i && bus.wb_long_i;

    // x0 is never tracked: permanently idle.
    assign cnt_vec[0]  = '0;
    assign full_vec[0] = 1'b0;
    assign zero_vec[0] = 1'b1;
    assign dec_vec[0]  = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_file_sb_counter #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk     (clk_i),
            .rst     (rst_i),
            .inc_req (bus.iss_en_i && (bus.iss_rd_i == reg_addr_t'(r))),
            .dec_req (wb_long_hit && (bus.wb_rd_i == reg_addr_t'(r))),
            .cnt     (cnt_vec[r]),
            .full    (full_vec[r]),
            .zero    (zero_vec[r]),
            .dec     (dec_vec[r])
        );
    end

    // Architectural storage; x0 is never written so it stays zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.rf_rw_en_i && (bus.wb_rd_i != '0)) begin
            regs_q[bus.wb_rd_i] <= bus.wb_data_i;
        end
    end

    // Read ports with write-first bypass of the writeback value.
    always_comb begin
        bus.rs1_data_o = regs_q[bus.rs1_addr_i];
        bus.rs2_data_o = regs_q[bus.rs2_addr_i];
        if (bus.rs1_addr_i == '0) begin
            bus.rs1_data_o = '0;
        end else if (bus.rf_rw_en_i && (bus.wb_rd_i == bus.rs1_addr_i)) begin
            bus.rs1_data_o = bus.wb_data_i;
        end
        if (bus.rs2_addr_i == '0) begin
            bus.rs2_data_o = '0;
        end else if (bus.rf_rw_en_i && (bus.wb_rd_i == bus.rs2_addr_i)) begin
            bus.rs2_data_o = bus.wb_data_i;
        end
    end

    // Busy unless the last outstanding write retires this cycle (bypass covers it).
    always_comb begin
        bus.rs1_busy_o = !zero_vec[bus.rs1_addr_i] &&
                         !(dec_vec[bus.rs1_addr_i] && (cnt_vec[bus.rs1_addr_i] == PEND_W'(1)));
        bus.rs2_busy_o = !zero_vec[bus.rs2_addr_i] &&
                         !(dec_vec[bus.rs2_addr_i] && (cnt_vec[bus.rs2_addr_i] == PEND_W'(1)));
        bus.iss_full_o = full_vec[bus.iss_rd_i];
        underflow      = wb_long_hit && (bus.wb_rd_i != '0) && zero_vec[bus.wb_rd_i];
    end

    // Underflow is reported one cycle later as a single-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= underflow;
        end
    end

    assign bus.sb_err_o = sb_err_q;

endmodule
